store_commit_buffer: RTL and testbench

//  FIFO of committed stores between the commit stage and the data SRAM port, downstream of the AGU.

---
 rtl/store_commit_buffer.sv | 144 ++++++++++++++
 tb/tb_store_commit_buffer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/store_commit_buffer.sv
// Committed-store FIFO between commit and the data SRAM port. Stores drain in
// commit order on cycles with no granted load; loads hitting a pending word are held.
module store_commit_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cm_store_en,
    input  logic [3:0]         cm_store_sel,
    input  logic [31:0]        cm_store_addr,
    input  logic [31:0]        cm_store_wdata,
    input  logic               ld_en,
    input  logic [31:0]        ld_addr,
    output logic               sb_full,
    output logic               sb_empty,
    output logic [PTR_W:0]     sb_count,
    output logic               ld_conflict,
    output logic               sb_overflow,
    output logic               data_sram_en,
    output logic [3:0]         data_sram_wen,
    output logic [31:0]        data_sram_addr,
    output logic [31:0]        data_sram_wdata
);

    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [31:0]      addr_q  [DEPTH];
    logic [31:0]      addr_d  [DEPTH];
    logic [3:0]       sel_q   [DEPTH];
    logic [3:0]       sel_d   [DEPTH];
    logic [31:0]      wdata_q [DEPTH];
    logic [31:0]      wdata_d [DEPTH];
    logic             overflow_q, overflow_d;

    logic enq_s, deq_s, ld_grant_s, hit_s;

    assign sb_full     = (count_q == CNT_FULL);
    assign sb_empty    = (count_q == {(PTR_W+1){1'b0}});
    assign sb_count    = count_q;
    assign sb_overflow = overflow_q;

    // Word-address match of the load against pending and committing stores.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][31:2] == ld_addr[31:2])) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
        ld_conflict = ld_en && (hit_s || (cm_store_en && (cm_store_addr[31:2] == ld_addr[31:2])));
    end

    // SRAM port arbitration; a granted load always wins over the drain.
    always_comb begin
        ld_grant_s      = ld_en && !ld_conflict;
        deq_s           = !ld_grant_s && !sb_empty;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = 32'h0000_0000;
        data_sram_wdata = 32'h0000_0000;
        if (!resetn) begin
            deq_s = 1'b0;
        end else if (ld_grant_s) begin
            data_sram_en   = 1'b1;
            data_sram_addr = ld_addr;
        end else if (deq_s) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = sel_q[rd_ptr_q];
            data_sram_addr  = addr_q[rd_ptr_q];
            data_sram_wdata = wdata_q[rd_ptr_q];
        end else begin
            data_sram_en = 1'b0;
        end
    end

    // Next-state: fullness is judged on the registered count, so a same-cycle
    // drain never makes room for that cycle's commit.
    always_comb begin
        enq_s      = cm_store_en && !sb_full;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        overflow_d = overflow_q || (cm_store_en && sb_full);
        if (deq_s) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (enq_s) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = cm_store_addr;
            sel_d[wr_ptr_q]   = cm_store_sel;
            wdata_d[wr_ptr_q] = cm_store_wdata;
            wr_ptr_d          = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {(PTR_W+1){1'b0}};
            valid_q    <= {DEPTH{1'b0}};
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= 32'h0000_0000;
                sel_q[i]   <= 4'b0000;
                wdata_q[i] <= 32'h0000_0000;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: vector table plus hand-written sequences,
// with a store scoreboard that predicts conflicts, drains and counts.
module tb_store_commit_buffer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cm_store_en;
    logic [3:0]  cm_store_sel;
    logic [31:0] cm_store_addr;
    logic [31:0] cm_store_wdata;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic        sb_full, sb_empty, ld_conflict, sb_overflow;
    logic [3:0]  sb_count;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;

    store_commit_buffer #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .resetn(resetn),
        .cm_store_en(cm_store_en), .cm_store_sel(cm_store_sel),
        .cm_store_addr(cm_store_addr), .cm_store_wdata(cm_store_wdata),
        .ld_en(ld_en), .ld_addr(ld_addr),
        .sb_full(sb_full), .sb_empty(sb_empty), .sb_count(sb_count),
        .ld_conflict(ld_conflict), .sb_overflow(sb_overflow),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } st_t;

    typedef struct {
        logic        c;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        le;
        logic [31:0] la;
        logic        e_conf;
        logic        e_en;
        logic [3:0]  e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        int          e_count;
    } vec_t;

    st_t  sbq[$];
    logic m_ovf;
    int   n_vec  = 0;
    int   n_fail = 0;

    logic        cap_conf, cap_en;
    logic [3:0]  cap_wen;
    logic [31:0] cap_addr, cap_wdata;
    int          cap_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at posedge+1, predict and compare at the negedge.
    task automatic step(input logic c, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, input logic le, input logic [31:0] la);
        logic conf, grant, drain, acc;
        st_t  h;
        cm_store_en = c; cm_store_sel = s; cm_store_addr = a; cm_store_wdata = d;
        ld_en = le; ld_addr = la;
        conf = 1'b0;
        if (le) begin
            foreach (sbq[i]) if (sbq[i].addr[31:2] == la[31:2]) conf = 1'b1;
            if (c && (a[31:2] == la[31:2])) conf = 1'b1;
        end
        grant = le && !conf;
        drain = !grant && (sbq.size() != 0);
        acc   = c && (sbq.size() < 8);
        #4;
        cap_conf = ld_conflict; cap_en = data_sram_en; cap_wen = data_sram_wen;
        cap_addr = data_sram_addr; cap_wdata = data_sram_wdata; cap_count = int'(sb_count);
        check("ld_conflict", {31'd0, ld_conflict}, {31'd0, conf});
        check("sb_count", {28'd0, sb_count}, 32'(sbq.size()));
        check("sb_full", {31'd0, sb_full}, {31'd0, sbq.size() == 8});
        check("sb_empty", {31'd0, sb_empty}, {31'd0, sbq.size() == 0});
        check("sb_overflow", {31'd0, sb_overflow}, {31'd0, m_ovf});
        if (grant) begin
            check("ld_en_out", {31'd0, data_sram_en}, 32'd1);
            check("ld_wen", {28'd0, data_sram_wen}, 32'd0);
            check("ld_addr_out", data_sram_addr, la);
            check("ld_wdata", data_sram_wdata, 32'd0);
        end else if (drain) begin
            h = sbq.pop_front();
            check("st_en", {31'd0, data_sram_en}, 32'd1);
            check("st_wen", {28'd0, data_sram_wen}, {28'd0, h.sel});
            check("st_addr", data_sram_addr, h.addr);
            check("st_wdata", data_sram_wdata, h.wdata);
        end else begin
            check("idle_en", {31'd0, data_sram_en}, 32'd0);
            check("idle_wen", {28'd0, data_sram_wen}, 32'd0);
            check("idle_addr", data_sram_addr, 32'd0);
        end
        if (acc) sbq.push_back('{a, s, d});
        if (c && !acc) m_ovf = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cm_store_en = 1'b0; cm_store_sel = 4'h0; cm_store_addr = 32'h0; cm_store_wdata = 32'h0;
        ld_en = 1'b0; ld_addr = 32'h0;
        sbq.delete();
        m_ovf = 1'b0;
        #1;
        check("rst_empty", {31'd0, sb_empty}, 32'd1);
        check("rst_full", {31'd0, sb_full}, 32'd0);
        check("rst_count", {28'd0, sb_count}, 32'd0);
        check("rst_ovf", {31'd0, sb_overflow}, 32'd0);
        check("rst_sram_en", {31'd0, data_sram_en}, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    vec_t vt[9];

    initial begin
        vt[0] = '{1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        0};
        vt[1] = '{1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 32'h0,   1'b0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1};
        vt[2] = '{1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        0};
        vt[3] = '{1'b1, 4'h4, 32'h104, 32'hABABABAB, 1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        0};
        vt[4] = '{1'b0, 4'h0, 32'h0,   32'h0,        1'b1, 32'h106, 1'b1, 1'b1, 4'h4, 32'h104, 32'hABABABAB, 1};
        vt[5] = '{1'b0, 4'h0, 32'h0,   32'h0,        1'b1, 32'h106, 1'b0, 1'b1, 4'h0, 32'h106, 32'h0,        0};
        vt[6] = '{1'b1, 4'h3, 32'h300, 32'h12341234, 1'b1, 32'h300, 1'b1, 1'b0, 4'h0, 32'h0,   32'h0,        0};
        vt[7] = '{1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 32'h0,   1'b0, 1'b1, 4'h3, 32'h300, 32'h12341234, 1};
        vt[8] = '{1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        0};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(vt[i].c, vt[i].sel, vt[i].addr, vt[i].wdata, vt[i].le, vt[i].la);
            check($sformatf("vt%0d_conf", i), {31'd0, cap_conf}, {31'd0, vt[i].e_conf});
            check($sformatf("vt%0d_en", i), {31'd0, cap_en}, {31'd0, vt[i].e_en});
            check($sformatf("vt%0d_wen", i), {28'd0, cap_wen}, {28'd0, vt[i].e_wen});
            check($sformatf("vt%0d_addr", i), cap_addr, vt[i].e_addr);
            check($sformatf("vt%0d_wdata", i), cap_wdata, vt[i].e_wdata);
            check($sformatf("vt%0d_count", i), 32'(cap_count), 32'(vt[i].e_count));
        end

        // Fill behind a held load, overflow, then drain in order.
        for (int i = 0; i < 8; i++)
            step(1'b1, 4'hF, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, 32'h200);
        check("fill_full", {31'd0, sb_full}, 32'd1);
        check("fill_count", {28'd0, sb_count}, 32'd8);
        step(1'b1, 4'hF, 32'h20, 32'hBAD0BAD0, 1'b1, 32'h200);
        check("ovf_set", {31'd0, sb_overflow}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
            check("drain_order", cap_addr, 32'(i * 4));
        end
        idle(1);

        // Full with a same-cycle drain: commit still dropped.
        do_reset();
        for (int i = 0; i < 8; i++)
            step(1'b1, 4'h1, 32'h400 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b1, 32'h800);
        step(1'b1, 4'h2, 32'h500, 32'h55555555, 1'b0, 32'h0);
        check("full_drop_count", {28'd0, sb_count}, 32'd7);
        check("full_drop_ovf", {31'd0, sb_overflow}, 32'd1);
        idle(4);
        check("mid_count", {28'd0, sb_count}, 32'd3);
        for (int i = 0; i < 10; i++)
            step(1'b1, 4'(i), 32'h600 + 32'(i * 4), 32'($urandom), 1'b0, 32'h0);
        check("steady_count", {28'd0, sb_count}, 32'd3);
        idle(4);

        // Asynchronous reset with entries pending.
        for (int i = 0; i < 5; i++)
            step(1'b1, 4'hF, 32'h700 + 32'(i * 4), 32'(i), 1'b1, 32'h900);
        cm_store_en = 1'b0; ld_en = 1'b0;
        #2;
        check("pre_rst_en", {31'd0, data_sram_en}, 32'd1);
        resetn = 1'b0;
        #1;
        check("async_en", {31'd0, data_sram_en}, 32'd0);
        check("async_empty", {31'd0, sb_empty}, 32'd1);
        check("async_count", {28'd0, sb_count}, 32'd0);
        sbq.delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
